// File: rtl/ecp5pll_phase_pkg.sv
// Shared types and default timing for the ECP5 PLL dynamic phase sequencer.
// ECP5PLL_PHASE_LOCKWAIT_EN adds the LOCKWAIT state to the state enum.
package ecp5pll_phase_pkg;

   localparam int PH_SETUP_CYC    = 2;
   localparam int PH_PULSE_CYC    = 4;
   localparam int PH_GAP_CYC      = 4;
   localparam int PH_STEP_W       = 10;
   localparam int PH_POS_W        = 16;
   localparam int PH_LOCK_TIMEOUT = 65535;

   // Storage width of the step field in the latched request; any STEP_W up
   // to this fits without truncation.
   localparam int PH_STEPS_MAX_W  = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_PULSE    = 3'd2,
      ST_GAP      = 3'd3,
      ST_LOAD     = 3'd4,
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
      ST_LOCKWAIT = 3'd5,
`endif
      ST_DONE     = 3'd6
   } phase_state_e;

   typedef struct packed {
      logic [1:0]                chan;
      logic                      dir;
      logic                      load;
      logic [PH_STEPS_MAX_W-1:0] steps;
   } phase_req_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ecp5pll_phase_ctrl_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
   input  logic clk_i,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic s1_q, s2_q;

   // Resample the async input twice before anyone looks at it.
   always_ff @(posedge clk_i) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// Request sequencer for the ECP5 PLL dynamic phase port: steps/loads one
// output, tracks per-output phase position, and watches PLL lock.
// Define ECP5PLL_PHASE_LOCKWAIT_EN to wait for lock before reporting done.
module ecp5pll_phase_ctrl
   import ecp5pll_phase_pkg::*;
#(
   parameter int SETUP_CYC    = PH_SETUP_CYC,
   parameter int PULSE_CYC    = PH_PULSE_CYC,
   parameter int GAP_CYC      = PH_GAP_CYC,
   parameter int STEP_W       = PH_STEP_W,
   parameter int POS_W        = PH_POS_W,
   parameter int LOCK_TIMEOUT = PH_LOCK_TIMEOUT
) (
   input  logic              clk_i,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_chan,
   input  logic              req_dir,
   input  logic              req_load,
   input  logic [STEP_W-1:0] req_steps,
   output logic              done,
   output logic              done_err,
   output logic              busy,
   output logic [1:0]        phasesel,
   output logic              phasedir,
   output logic              phasestep,
   output logic              phaseloadreg,
   input  logic              locked_i,
   output logic              locked_o,
   output logic              lock_lost,
   input  logic              lock_clr,
   input  logic [1:0]        pos_sel,
   output logic [POS_W-1:0]  pos_o
);

   localparam int CNT_W = $clog2(max3(SETUP_CYC, PULSE_CYC, GAP_CYC) + 1);
   localparam logic [CNT_W-1:0]          CNT_ONE  = 1;
   localparam logic [POS_W-1:0]          POS_ONE  = 1;
   localparam logic [PH_STEPS_MAX_W-1:0] STEP_ONE = 1;
   localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_CYC - 1);

`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
   localparam phase_state_e LOCK_STAGE = ST_LOCKWAIT;
   localparam int WT_W = $clog2(LOCK_TIMEOUT + 1);
   logic [WT_W-1:0] wt_q, wt_d;
   logic            err_d;
   logic            done_err_q;
`else
   localparam phase_state_e LOCK_STAGE = ST_DONE;
`endif

   phase_state_e                 state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   phase_req_t                   req_q, req_d;
   logic [3:0][POS_W-1:0]        pos_q, pos_d;
   logic ready_q, busy_q, done_q, step_q, load_q;
   logic lk_prev_q, lock_lost_q;

   sync2 u_lock_sync (
      .clk_i (clk_i),
      .reset (reset),
      .d_i   (locked_i),
      .q_o   (locked_o)
   );

   // Next-state, step/position bookkeeping; cnt_q counts cycles spent in
   // the current state and restarts at 0 on every state change.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_ONE;
      req_d   = req_q;
      pos_d   = pos_q;
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
      wt_d    = '0;
      err_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (req_valid && ready_q) begin
               req_d.chan  = req_chan;
               req_d.dir   = req_dir;
               req_d.load  = req_load;
               req_d.steps = PH_STEPS_MAX_W'(req_steps);
               state_d     = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_q == SETUP_END) begin
               cnt_d = '0;
               if (req_q.load)              state_d = ST_LOAD;
               else if (req_q.steps != '0)  state_d = ST_PULSE;
               else                         state_d = LOCK_STAGE;
            end
         end
         ST_PULSE: begin
            // Position moves once per pulse, in the pulse's first cycle.
            if (cnt_q == '0) begin
               pos_d[req_q.chan] = req_q.dir ? pos_q[req_q.chan] - POS_ONE
                                             : pos_q[req_q.chan] + POS_ONE;
               req_d.steps = req_q.steps - STEP_ONE;
            end
            if (cnt_q == PULSE_END) begin
               cnt_d   = '0;
               state_d = ST_GAP;
            end
         end
         ST_LOAD: begin
            if (cnt_q == '0) begin
               pos_d[req_q.chan] = '0;
               req_d.steps       = '0;
            end
            if (cnt_q == PULSE_END) begin
               cnt_d   = '0;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_END) begin
               cnt_d   = '0;
               state_d = (req_q.steps != '0) ? ST_PULSE : LOCK_STAGE;
            end
         end
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
         ST_LOCKWAIT: begin
            cnt_d = '0;
            wt_d  = wt_q + WT_W'(1);
            if (locked_o) begin
               state_d = ST_DONE;
            end else if (wt_q == WT_W'(LOCK_TIMEOUT)) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end
         end
`endif
         ST_DONE: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM register; every output is registered from the next state so the
   // PLL sees glitch-free waveforms.
   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         pos_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         step_q  <= 1'b0;
         load_q  <= 1'b0;
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
         wt_q       <= '0;
         done_err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         pos_q   <= pos_d;
         ready_q <= (state_d == ST_IDLE);
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= (state_d == ST_DONE);
         step_q  <= (state_d == ST_PULSE);
         load_q  <= (state_d == ST_LOAD);
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
         wt_q       <= wt_d;
         done_err_q <= (state_d == ST_DONE) && err_d;
`endif
      end
   end

   // Sticky lock-loss flag; a fresh fall beats a simultaneous clear.
   always_ff @(posedge clk_i) begin
      if (reset) begin
         lk_prev_q   <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         lk_prev_q <= locked_o;
         if (lk_prev_q && !locked_o) lock_lost_q <= 1'b1;
         else if (lock_clr)          lock_lost_q <= 1'b0;
      end
   end

   assign req_ready    = ready_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign phasestep    = step_q;
   assign phaseloadreg = load_q;
   assign phasesel     = req_q.chan;
   assign phasedir     = req_q.dir;
   assign lock_lost    = lock_lost_q;
   assign pos_o        = pos_q[pos_sel];
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
   assign done_err     = done_err_q;
`else
   assign done_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Directed + randomized bench for ecp5pll_phase_ctrl against a timing and
// position model derived from the request rules.
module tb_ecp5pll_phase_ctrl;

   localparam int SETUP = 2;
   localparam int PULSE = 4;
   localparam int GAP   = 4;

   logic        clk_i = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_chan = '0;
   logic        req_dir = 1'b0;
   logic        req_load = 1'b0;
   logic [9:0]  req_steps = '0;
   logic        done, done_err, busy;
   logic [1:0]  phasesel;
   logic        phasedir, phasestep, phaseloadreg;
   logic        locked_i = 1'b1;
   logic        locked_o, lock_lost;
   logic        lock_clr = 1'b0;
   logic [1:0]  pos_sel = '0;
   logic [15:0] pos_o;

   int total = 0;
   int bad   = 0;
   logic [15:0] mpos [4];

   ecp5pll_phase_ctrl dut (
      .clk_i(clk_i), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_chan(req_chan),
      .req_dir(req_dir), .req_load(req_load), .req_steps(req_steps),
      .done(done), .done_err(done_err), .busy(busy),
      .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
      .phaseloadreg(phaseloadreg), .locked_i(locked_i), .locked_o(locked_o),
      .lock_lost(lock_lost), .lock_clr(lock_clr), .pos_sel(pos_sel), .pos_o(pos_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_pos(input string tag);
      for (int c = 0; c < 4; c++) begin
         pos_sel = 2'(c);
         #1;
         chk($sformatf("%s_pos%0d", tag, c), {16'h0, pos_o}, {16'h0, mpos[c]});
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      chk("ready_wait", {31'h0, req_ready}, 32'h1);
   endtask

   // Issue one request and measure the waveform it produces.
   task automatic run_req(input logic [1:0] ch, input logic dr, input logic ld,
                          input int steps);
      int k = 1, done_k = -1, rises = 0, first_rise = -1, last_rise = -1;
      int step_hi = 0, load_hi = 0, load_first = -1, sel_bad = 0, busy_bad = 0;
      int n_eff, exp_done;
      logic prev_st = 1'b0;
      wait_ready();
      req_chan = ch; req_dir = dr; req_load = ld; req_steps = 10'(steps);
      req_valid = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      req_valid = 1'b0;
      while (k < 400 && done_k < 0) begin
         if (phasestep && !prev_st) begin
            if (rises == 0) first_rise = k;
            last_rise = k;
            rises++;
         end
         prev_st = phasestep;
         step_hi += int'(phasestep);
         if (phaseloadreg && load_first < 0) load_first = k;
         load_hi += int'(phaseloadreg);
         if (phasesel !== ch || phasedir !== dr) sel_bad++;
         if (busy !== 1'b1 || req_ready !== 1'b0) busy_bad++;
         if (done === 1'b1) begin
            done_k = k;
            chk("done_err", {31'h0, done_err}, 32'h0);
         end else begin
            @(negedge clk_i);
            k++;
         end
      end
      n_eff    = ld ? 1 : steps;
      exp_done = 1 + SETUP + n_eff * (PULSE + GAP);
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
      exp_done += 1;
`endif
      chk($sformatf("done_time ch%0d n%0d ld%0d", ch, steps, ld), done_k, exp_done);
      chk("sel_dir_stable", sel_bad, 0);
      chk("busy_window", busy_bad, 0);
      if (ld) begin
         chk("load_no_step", rises, 0);
         chk("load_hi", load_hi, PULSE);
         chk("load_rise", load_first, 1 + SETUP);
      end else begin
         chk("step_count", rises, steps);
         chk("step_hi", step_hi, steps * PULSE);
         chk("no_load", load_hi, 0);
         if (steps > 0) begin
            chk("first_rise", first_rise, 1 + SETUP);
            chk("last_rise", last_rise, 1 + SETUP + (steps - 1) * (PULSE + GAP));
         end
      end
      @(negedge clk_i);
      chk("done_one_cycle", {30'h0, done, busy}, 32'h0);
      if (ld) mpos[ch] = 16'h0;
      else if (dr) mpos[ch] = mpos[ch] - 16'(steps);
      else mpos[ch] = mpos[ch] + 16'(steps);
      check_pos($sformatf("after_ch%0d", ch));
   endtask

   initial begin
      int n;
      for (int c = 0; c < 4; c++) mpos[c] = 16'h0;

      // Reset state
      repeat (3) @(negedge clk_i);
      chk("rst_outs", {21'h0, req_ready, done, done_err, busy, phasesel, phasedir,
                       phasestep, phaseloadreg, locked_o, lock_lost}, 32'h0);
      check_pos("rst");
      reset = 1'b0;

      // Directed requests
      run_req(2'd1, 1'b0, 1'b0, 3);
      run_req(2'd2, 1'b1, 1'b0, 2);
      chk("wrap_fffe", {16'h0, mpos[2]}, 32'hFFFE);
      run_req(2'd3, 1'b0, 1'b0, 5);
      run_req(2'd3, 1'b0, 1'b1, 7);
      run_req(2'd0, 1'b0, 1'b0, 0);

      // Randomized requests
      for (int i = 0; i < 8; i++) begin
         run_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0), int'($urandom_range(0, 6)));
      end

      // Reset in the middle of a long stepping request
      wait_ready();
      req_chan = 2'd0; req_dir = 1'b0; req_load = 1'b0; req_steps = 10'd10;
      req_valid = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      req_valid = 1'b0;
      n = 0;
      while (!phasestep && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      chk("midpulse_reached", {31'h0, phasestep}, 32'h1);
      @(negedge clk_i);
      reset = 1'b1;
      @(negedge clk_i);
      chk("midrst_outs", {21'h0, req_ready, done, done_err, busy, phasesel, phasedir,
                          phasestep, phaseloadreg, locked_o, lock_lost}, 32'h0);
      for (int c = 0; c < 4; c++) mpos[c] = 16'h0;
      check_pos("midrst");
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         n += int'(done);
      end
      chk("no_done_after_rst", n, 0);
      run_req(2'd1, 1'b1, 1'b0, 1);
      chk("post_rst_ffff", {16'h0, mpos[1]}, 32'hFFFF);

      // Lock monitoring
      chk("locked_up", {31'h0, locked_o}, 32'h1);
      locked_i = 1'b0;
      @(negedge clk_i);
      chk("lk_lag1", {31'h0, locked_o}, 32'h1);
      @(negedge clk_i);
      chk("lk_lag2", {30'h0, locked_o, lock_lost}, 32'h0);
      @(negedge clk_i);
      chk("lost_set", {31'h0, lock_lost}, 32'h1);
      repeat (2) @(negedge clk_i);
      locked_i = 1'b1;
      repeat (4) @(negedge clk_i);
      chk("lost_sticky", {30'h0, locked_o, lock_lost}, 32'h3);
      locked_i = 1'b0;
      repeat (2) @(negedge clk_i);
      lock_clr = 1'b1;
      @(negedge clk_i);
      lock_clr = 1'b0;
      chk("set_wins", {31'h0, lock_lost}, 32'h1);
      locked_i = 1'b1;
      repeat (4) @(negedge clk_i);
      lock_clr = 1'b1;
      @(negedge clk_i);
      lock_clr = 1'b0;
      chk("clr", {30'h0, locked_o, lock_lost}, 32'h2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ecp5pll_phase_ctrl.md
# ecp5pll_phase_ctrl

Sequencer for the dynamic phase-shift port of the ECP5 PLL wrapper (`ecp5pll` with `dynamic_en=1`). It accepts phase-shift and phase-load requests over a valid/ready handshake, then generates correctly timed `phasesel`/`phasedir`/`phasestep`/`phaseloadreg` waveforms. It tracks the accumulated phase position of each of the four PLL outputs and synchronizes and monitors the PLL lock signal. It sits between the board-level control logic (UART/debug registers) and the PLL wrapper, in the PLL's reference clock domain.

## Interface
- `SETUP_CYC`, 2: cycles `phasesel`/`phasedir` are held stable before the first pulse (≥1).
- `PULSE_CYC`, 4: high time of each `phasestep`/`phaseloadreg` pulse, in cycles (≥1).
- `GAP_CYC`, 4: low time after each pulse, in cycles (≥1).
- `STEP_W`, 10: width of the step-count field.
- `POS_W`, 16: width of each per-channel position counter.
- `LOCK_TIMEOUT`, 65535: cycles to wait for lock after a request (used only with the macro).
- `clk_i`  in  1  sole clock; the PLL input clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_chan`  in  2  logical output: 0 = out0 … 3 = out3.
- `req_dir`  in  1  0 = advance (+1 per step), 1 = retard (−1 per step).
- `req_load`  in  1  1 = issue one `phaseloadreg` pulse instead of steps.
- `req_steps`  in  STEP_W  number of `phasestep` pulses.
- `done`  out  1  one-cycle completion strobe.
- `done_err`  out  1  valid with `done`; lock timeout.
- `busy`  out  1  high in any non-IDLE state.
- `phasesel`  out  2  to wrapper `phasesel` (logical index).
- `phasedir`, `phasestep`, `phaseloadreg`  out  1 each  to wrapper.
- `locked_i`  in  1  raw PLL `locked`; treated as asynchronous.
- `locked_o`  out  1  `locked_i` after a 2-flop synchronizer.
- `lock_lost`  out  1  sticky: `locked_o` fell 1→0.
- `lock_clr`  in  1  clears `lock_lost`.
- `pos_sel`  in  2  position read select.
- `pos_o`  out  POS_W  combinational read of `pos[pos_sel]`.

## Operation
- States: IDLE, SETUP, PULSE, GAP, LOAD, LOCKWAIT (macro only), DONE.
- IDLE: when `req_valid & req_ready`, latch chan/dir/load/steps into registers and drive `phasesel`/`phasedir` from the latched values next cycle. Go to SETUP.
- SETUP: runs for `SETUP_CYC` cycles, then:
  - to LOAD if load is set;
  - to PULSE if the remaining step count is >0;
  - otherwise to the lock stage (LOCKWAIT if compiled in, else DONE).
- PULSE: `phasestep`=1 for `PULSE_CYC` cycles. On entry, `pos[chan]` changes by ±1 (modulo 2^POS_W) and the remaining count decrements.
- GAP: `phasestep`=0 for `GAP_CYC` cycles, then to PULSE if remaining >0, else to the lock stage.
- LOAD: `phaseloadreg`=1 for `PULSE_CYC` cycles, `pos[chan]` cleared to 0, then GAP (remaining = 0).
- DONE: `done`=1 for one cycle, then IDLE. `phasesel`/`phasedir` hold their last values in IDLE.
- Requests arriving while busy are not accepted; `req_ready`=0.
- `lock_lost`: set on the `locked_o` falling edge; cleared by `lock_clr`. If set and clear occur in the same cycle, set wins.
- Reset:
  - all outputs are 0;
  - `pos[*]`=0, synchronizer flops 0, `lock_lost`=0, state IDLE;
  - reset mid-operation aborts immediately with no `done`;
  - `phasestep`/`phaseloadreg` are 0 in the cycle after reset is sampled.

## Timing
- Let T be the accept cycle.
- `busy`=1 from T+1 through the DONE cycle.
- The first `phasestep` rises at T+1+SETUP_CYC.
- Without the macro, `done` fires at T+1+SETUP_CYC+N·(PULSE_CYC+GAP_CYC), where N is the step count. For N=0, `done` fires at T+1+SETUP_CYC.
- A load request has the same timing as N=1.
- All waveform outputs are registered and glitch-free. `pos_o` is updated one cycle after PULSE or LOAD entry.
- `locked_o` lags `locked_i` by 2 cycles.

## Configuration
- `ECP5PLL_PHASE_LOCKWAIT_EN` defined: the lock stage is LOCKWAIT, with a counter of LOCK_TIMEOUT width.
  - Exit to DONE on the first cycle `locked_o`=1, with `done_err`=0.
  - If the counter reaches LOCK_TIMEOUT first, exit to DONE with `done_err`=1.
  - `done` is delayed by the wait length.
- Undefined: no LOCKWAIT state and no counter. `done_err` is tied to 0.

## Structure
- Package `ecp5pll_phase_pkg`:
  - state enum;
  - request struct {chan, dir, load, steps};
  - default timing constants.
- Sub-module `sync2`: the lock synchronizer, reusable for other async inputs.
- The position array and FSM live in the top module.

## Test plan
- Reset, then ch1, dir0, steps=3 → `phasesel`=1 and `phasedir`=0 from T+1. Three `phasestep` pulses, each 4 cycles high, rising at T+3, T+11, T+19. `done` at T+27. `pos[1]`=3.
- ch2, dir1, steps=2 from pos 0 → `pos[2]`=0xFFFE (wrap). `done` at T+19.
- ch3 steps=5, then a load on ch3 → one 4-cycle `phaseloadreg` pulse, `pos[3]`=0, no `phasestep` activity.
- steps=0 → no pulses. `done` at T+3. `pos` unchanged.
- `reset` asserted mid-PULSE of a 10-step request → next cycle all outputs 0, `pos`=0, no `done`. A new request is accepted afterwards.
- Drop `locked_i` for 5 cycles → `lock_lost`=1 at drop+3. With `lock_clr` in the same cycle as a new fall, `lock_lost` stays 1. With the macro, `locked_i`=0 throughout → `done_err`=1 after LOCK_TIMEOUT.
